// File: rtl/weight_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : weight_buffer_if
// Description : Write bus, stream handshake and status signals of the
//               weight buffer. The master side is the loader/consumer, the
//               slave side is the weight buffer itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface weight_buffer_if #(
  parameter int DATA_WIDTH = 5,
  parameter int ARRAY_DIM  = 8,
  parameter int ADDR_WIDTH = $clog2(ARRAY_DIM * ARRAY_DIM)
);
  localparam int IDX_WIDTH = $clog2(ARRAY_DIM);

  // Write path
  logic [ADDR_WIDTH-1:0]           Weight_Mem_Address_in;
  logic [DATA_WIDTH-1:0]           Weight_Data;
  logic                            Weight_Write;
  // Control
  logic                            load_mem_done;
  logic                            Load_Start;
  // Row stream
  logic                            Row_Ready;
  logic                            Row_Valid;
  logic [ARRAY_DIM*DATA_WIDTH-1:0] Row_Data;
  logic [IDX_WIDTH-1:0]            Row_Index;
  // Status
  logic                            Load_Busy;
  logic                            Load_Done;
  logic [ADDR_WIDTH:0]             Write_Count;
  logic                            Write_Error;

  modport master (
    output Weight_Mem_Address_in, Weight_Data, Weight_Write,
    output load_mem_done, Load_Start, Row_Ready,
    input  Row_Valid, Row_Data, Row_Index,
    input  Load_Busy, Load_Done, Write_Count, Write_Error
  );

  modport slave (
    input  Weight_Mem_Address_in, Weight_Data, Weight_Write,
    input  load_mem_done, Load_Start, Row_Ready,
    output Row_Valid, Row_Data, Row_Index,
    output Load_Busy, Load_Done, Write_Count, Write_Error
  );
endinterface
`default_nettype wire

// File: rtl/weight_buffer.sv
`default_nettype none
// ============================================================================
// Module      : weight_buffer
// Description : ARRAY_DIM x ARRAY_DIM weight store. Written one word per
//               cycle while unlocked; once locked by load_mem_done it streams
//               one full row per Row_Valid/Row_Ready handshake, in ascending
//               (ROW_ORDER=0) or descending (ROW_ORDER=1) row order.
//               ARRAY_DIM must be a power of two >= 2 so that a word address
//               is simply {row, col}.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_buffer #(
  parameter int DATA_WIDTH = 5,
  parameter int ARRAY_DIM  = 8,
  parameter int DEPTH      = ARRAY_DIM * ARRAY_DIM,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int ROW_ORDER  = 1
) (
  input  wire logic      clk,
  input  wire logic      rst,
  weight_buffer_if.slave bus
);
  localparam int IDX_WIDTH = $clog2(ARRAY_DIM);
  localparam int ROW_WIDTH = ARRAY_DIM * DATA_WIDTH;
  localparam int CNT_WIDTH = ADDR_WIDTH + 1;

  localparam logic [IDX_WIDTH-1:0] c_first_row =
    (ROW_ORDER == 0) ? IDX_WIDTH'(0) : IDX_WIDTH'(ARRAY_DIM - 1);
  localparam logic [IDX_WIDTH-1:0] c_last_row =
    (ROW_ORDER == 0) ? IDX_WIDTH'(ARRAY_DIM - 1) : IDX_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0] c_depth = CNT_WIDTH'(DEPTH);

  typedef enum logic [1:0] {
    S_WRITE  = 2'd0,
    S_IDLE   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                 r_state;
  logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
  logic                   r_row_valid;
  logic [ROW_WIDTH-1:0]   r_row_data;
  logic [IDX_WIDTH-1:0]   r_row_idx;
  logic                   r_busy;
  logic                   r_done;
  logic [CNT_WIDTH-1:0]   r_wcount;
  logic                   r_werr;

  logic [IDX_WIDTH-1:0]   w_next_row;
  logic [IDX_WIDTH-1:0]   w_sel_row;
  logic [ROW_WIDTH-1:0]   w_sel_data;

  // Pick the row to load next: the first row when starting from IDLE,
  // otherwise the successor of the row currently presented.
  always_comb begin
    w_next_row = (ROW_ORDER == 0) ? (r_row_idx + IDX_WIDTH'(1))
                                  : (r_row_idx - IDX_WIDTH'(1));
    w_sel_row  = (r_state == S_IDLE) ? c_first_row : w_next_row;
  end

  // Gather all columns of the selected row; the memory is locked while
  // streaming, so reading it directly here is stable.
  for (genvar c = 0; c < ARRAY_DIM; c++) begin : g_col
    localparam logic [IDX_WIDTH-1:0] c_col = IDX_WIDTH'(c);
    assign w_sel_data[c*DATA_WIDTH +: DATA_WIDTH] = r_mem[{w_sel_row, c_col}];
  end

  // Control FSM, memory writes, row register and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_WRITE;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_row_valid <= 1'b0;
      r_row_data  <= '0;
      r_row_idx   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wcount    <= '0;
      r_werr      <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // Any write attempt while locked is dropped and flagged.
      if (bus.Weight_Write && (r_state != S_WRITE)) begin
        r_werr <= 1'b1;
      end

      case (r_state)
        S_WRITE: begin
          if (bus.Weight_Write) begin
            r_mem[bus.Weight_Mem_Address_in] <= bus.Weight_Data;
            if (r_wcount != c_depth) begin
              r_wcount <= r_wcount + CNT_WIDTH'(1);
            end
          end
          // Load_Start is deliberately not looked at on this edge.
          if (bus.load_mem_done) begin
            r_state <= S_IDLE;
          end
        end

        S_IDLE: begin
          if (!bus.load_mem_done) begin
            r_state  <= S_WRITE;
            r_wcount <= '0;
          end else if (bus.Load_Start) begin
            r_state     <= S_STREAM;
            r_row_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_row_idx   <= c_first_row;
            r_row_data  <= w_sel_data;
          end
        end

        S_STREAM: begin
          if (!bus.load_mem_done) begin
            // Abort: drop the stream without a completion pulse. A row
            // handshaken on this same edge is already delivered.
            r_state     <= S_WRITE;
            r_row_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_wcount    <= '0;
          end else if (bus.Row_Ready) begin
            if (r_row_idx == c_last_row) begin
              r_state     <= S_DONE;
              r_row_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_row_idx  <= w_next_row;
              r_row_data <= w_sel_data;
            end
          end
        end

        S_DONE: begin
          if (!bus.load_mem_done) begin
            r_state  <= S_WRITE;
            r_wcount <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_WRITE;
        end
      endcase
    end
  end

  assign bus.Row_Valid   = r_row_valid;
  assign bus.Row_Data    = r_row_data;
  assign bus.Row_Index   = r_row_idx;
  assign bus.Load_Busy   = r_busy;
  assign bus.Load_Done   = r_done;
  assign bus.Write_Count = r_wcount;
  assign bus.Write_Error = r_werr;

endmodule
`default_nettype wire

// File: tb/tb_weight_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_weight_buffer
// Description : Scoreboard bench for weight_buffer. Instance A uses default
//               parameters (8x8, 5 bit, descending); instance B is 4x4,
//               8 bit, ascending. Expected rows are queued when a stream is
//               requested and popped by per-instance monitors on acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_buffer;
  localparam int A_DW = 5, A_DIM = 8, A_AW = 6;
  localparam int B_DW = 8, B_DIM = 4, B_AW = 4;

  typedef struct {
    int          idx;
    logic [63:0] data;
  } row_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  weight_buffer_if #(.DATA_WIDTH(A_DW), .ARRAY_DIM(A_DIM), .ADDR_WIDTH(A_AW)) ifa ();
  weight_buffer_if #(.DATA_WIDTH(B_DW), .ARRAY_DIM(B_DIM), .ADDR_WIDTH(B_AW)) ifb ();

  weight_buffer dut_a (.clk(clk), .rst(rst), .bus(ifa));
  weight_buffer #(.DATA_WIDTH(B_DW), .ARRAY_DIM(B_DIM), .ROW_ORDER(0))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int total = 0;
  int bad   = 0;
  row_t qa[$];
  row_t qb[$];
  logic [A_DW-1:0] mem_a [A_DIM*A_DIM];
  logic [B_DW-1:0] mem_b [B_DIM*B_DIM];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] row_a(input int r);
    logic [63:0] v;
    v = '0;
    for (int c = 0; c < A_DIM; c++) v[c*A_DW +: A_DW] = mem_a[r*A_DIM + c];
    return v;
  endfunction

  function automatic logic [63:0] row_b(input int r);
    logic [63:0] v;
    v = '0;
    for (int c = 0; c < B_DIM; c++) v[c*B_DW +: B_DW] = mem_b[r*B_DIM + c];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor A: score accepted rows and check stability under backpressure.
  initial begin
    row_t e;
    logic [63:0] hd, hi;
    bit hold;
    hold = 0; hd = '0; hi = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        hold = 0;
      end else begin
        if (hold && ifa.Row_Valid) begin
          chk("hold_data_a", ifa.Row_Data, hd);
          chk("hold_index_a", 64'(ifa.Row_Index), hi);
        end
        if (ifa.Row_Valid && ifa.Row_Ready) begin
          if (qa.size() == 0) begin
            total++; bad++;
            $display("FAIL extra_row_a: got row %0d expected none", ifa.Row_Index);
          end else begin
            e = qa.pop_front();
            chk("row_index_a", 64'(ifa.Row_Index), 64'(e.idx));
            chk("row_data_a", 64'(ifa.Row_Data), e.data);
          end
        end
        hold = ifa.Row_Valid && !ifa.Row_Ready;
        hd   = 64'(ifa.Row_Data);
        hi   = 64'(ifa.Row_Index);
      end
    end
  end

  // Monitor B: score accepted rows.
  initial begin
    row_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && ifb.Row_Valid && ifb.Row_Ready) begin
        if (qb.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_row_b: got row %0d expected none", ifb.Row_Index);
        end else begin
          e = qb.pop_front();
          chk("row_index_b", 64'(ifb.Row_Index), 64'(e.idx));
          chk("row_data_b", 64'(ifb.Row_Data), e.data);
        end
      end
    end
  end

  task automatic chk_zero_a(input string tag);
    chk({tag, "_valid_a"}, 64'(ifa.Row_Valid), 0);
    chk({tag, "_data_a"},  64'(ifa.Row_Data), 0);
    chk({tag, "_index_a"}, 64'(ifa.Row_Index), 0);
    chk({tag, "_busy_a"},  64'(ifa.Load_Busy), 0);
    chk({tag, "_done_a"},  64'(ifa.Load_Done), 0);
    chk({tag, "_wcount_a"}, 64'(ifa.Write_Count), 0);
    chk({tag, "_werr_a"},  64'(ifa.Write_Error), 0);
  endtask

  task automatic write_a(input int addr, input int data);
    ifa.Weight_Write = 1'b1;
    ifa.Weight_Mem_Address_in = A_AW'(addr);
    ifa.Weight_Data = A_DW'(data);
    tick();
    ifa.Weight_Write = 1'b0;
  endtask

  task automatic write_b(input int addr, input int data);
    ifb.Weight_Write = 1'b1;
    ifb.Weight_Mem_Address_in = B_AW'(addr);
    ifb.Weight_Data = B_DW'(data);
    tick();
    ifb.Weight_Write = 1'b0;
  endtask

  // Full stream on A, optionally stalling 3 cycles on bp_row or dropping
  // load_mem_done while abort_row is presented (-1 disables either).
  task automatic stream_a(input int bp_row, input int abort_row, input int exp_cycles);
    row_t e;
    int cycles, bp_left;
    bit aborted;
    bp_left = 3; aborted = 0;
    for (int r = A_DIM - 1; r >= 0; r--) begin
      e.idx = r; e.data = row_a(r);
      qa.push_back(e);
    end
    ifa.Row_Ready = 1'b1;
    ifa.Load_Start = 1'b1;
    tick();
    ifa.Load_Start = 1'b0;
    cycles = 1;
    chk("first_valid_a", 64'(ifa.Row_Valid), 1);
    chk("first_busy_a", 64'(ifa.Load_Busy), 1);
    while (!ifa.Load_Done && !aborted && cycles < 40) begin
      ifa.Row_Ready = 1'b1;
      if (ifa.Row_Valid && int'(ifa.Row_Index) == bp_row && bp_left > 0) begin
        ifa.Row_Ready = 1'b0;
        bp_left--;
      end
      if (ifa.Row_Valid && int'(ifa.Row_Index) == abort_row) begin
        ifa.load_mem_done = 1'b0;
        aborted = 1;
      end
      tick();
      cycles++;
    end
    ifa.Row_Ready = 1'b1;
    if (aborted) begin
      chk("abort_valid_a", 64'(ifa.Row_Valid), 0);
      chk("abort_busy_a", 64'(ifa.Load_Busy), 0);
      chk("abort_done_a", 64'(ifa.Load_Done), 0);
      chk("abort_wcount_a", 64'(ifa.Write_Count), 0);
      chk("abort_rows_left_a", 64'(qa.size()), 64'(abort_row));
      qa.delete();
      tick();
      chk("abort_no_done_a", 64'(ifa.Load_Done), 0);
    end else begin
      chk("done_latency_a", 64'(cycles), 64'(exp_cycles));
      chk("done_valid_a", 64'(ifa.Row_Valid), 0);
      chk("done_busy_a", 64'(ifa.Load_Busy), 0);
      chk("rows_left_a", 64'(qa.size()), 0);
      qa.delete();
      tick();
      chk("done_pulse_a", 64'(ifa.Load_Done), 0);
    end
  endtask

  initial begin
    row_t e;
    int cycles;
    rst = 1'b0;
    ifa.Weight_Mem_Address_in = '0; ifa.Weight_Data = '0; ifa.Weight_Write = 1'b0;
    ifa.load_mem_done = 1'b0; ifa.Load_Start = 1'b0; ifa.Row_Ready = 1'b1;
    ifb.Weight_Mem_Address_in = '0; ifb.Weight_Data = '0; ifb.Weight_Write = 1'b0;
    ifb.load_mem_done = 1'b0; ifb.Load_Start = 1'b0; ifb.Row_Ready = 1'b1;
    tick(); tick();
    chk_zero_a("reset");
    chk("reset_valid_b", 64'(ifb.Row_Valid), 0);
    chk("reset_wcount_b", 64'(ifb.Write_Count), 0);
    rst = 1'b1;
    tick();

    // Fill A with addr[4:0]
    for (int a = 0; a < A_DIM*A_DIM; a++) begin
      write_a(a, a);
      mem_a[a] = A_DW'(a);
    end
    chk("fill_wcount_a", 64'(ifa.Write_Count), 64);
    chk("fill_werr_a", 64'(ifa.Write_Error), 0);

    // Load_Start on the WRITE->IDLE edge is ignored
    ifa.load_mem_done = 1'b1;
    ifa.Load_Start = 1'b1;
    tick();
    ifa.Load_Start = 1'b0;
    tick();
    chk("lock_start_ignored_a", 64'(ifa.Row_Valid), 0);
    chk("lock_busy_a", 64'(ifa.Load_Busy), 0);

    // Descending full-rate stream, then with backpressure on row 5
    stream_a(-1, -1, A_DIM + 1);
    stream_a(5, -1, A_DIM + 4);

    // Locked write is dropped and flagged
    write_a(0, 31);
    chk("locked_werr_a", 64'(ifa.Write_Error), 1);
    chk("locked_wcount_a", 64'(ifa.Write_Count), 64);
    tick();
    chk("werr_sticky_a", 64'(ifa.Write_Error), 1);
    stream_a(-1, -1, A_DIM + 1);

    // Abort during row 3, then write again
    stream_a(-1, 3, 0);
    write_a(5, 17);
    write_a(5, 9);
    mem_a[5] = A_DW'(9);
    chk("rewrite_wcount_a", 64'(ifa.Write_Count), 2);
    chk("werr_sticky2_a", 64'(ifa.Write_Error), 1);
    ifa.load_mem_done = 1'b1;
    tick();
    stream_a(-1, -1, A_DIM + 1);

    // Reset in the middle of a stream
    for (int r = A_DIM - 1; r >= 0; r--) begin
      e.idx = r; e.data = row_a(r);
      qa.push_back(e);
    end
    ifa.Load_Start = 1'b1;
    tick();
    ifa.Load_Start = 1'b0;
    tick(); tick();
    #2 rst = 1'b0;
    #1 chk_zero_a("async_reset");
    qa.delete();
    for (int a = 0; a < A_DIM*A_DIM; a++) mem_a[a] = '0;
    tick();
    rst = 1'b1;
    tick(); tick();
    stream_a(-1, -1, A_DIM + 1);

    // Instance B: 4x4, 8-bit, ascending
    for (int a = 0; a < B_DIM*B_DIM; a++) begin
      write_b(a, (a*17 + 3) & 255);
      mem_b[a] = B_DW'((a*17 + 3) & 255);
    end
    write_b(0, 3);
    write_b(0, 3);
    chk("sat_wcount_b", 64'(ifb.Write_Count), 16);
    chk("fill_werr_b", 64'(ifb.Write_Error), 0);
    ifb.load_mem_done = 1'b1;
    tick(); tick();
    for (int r = 0; r < B_DIM; r++) begin
      e.idx = r; e.data = row_b(r);
      qb.push_back(e);
    end
    ifb.Load_Start = 1'b1;
    tick();
    ifb.Load_Start = 1'b0;
    cycles = 1;
    while (!ifb.Load_Done && cycles < 40) begin
      tick();
      cycles++;
    end
    chk("done_latency_b", 64'(cycles), 64'(B_DIM + 1));
    chk("rows_left_b", 64'(qb.size()), 0);
    tick();
    chk("done_pulse_b", 64'(ifb.Load_Done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
